// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm : fetch/decode/exec/mem/wb control unit with ack timeouts
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap instead of acting as NOP
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl_fsm #(
  parameter int IW       = 16,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] instr_i,
  input  logic          zero_i,
  output logic          imem_req_o,
  input  logic          imem_ack_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  input  logic          dmem_ack_i,
  output logic          ir_we_o,
  output logic          pc_we_o,
  output logic [1:0]    pc_src_o,
  output logic [2:0]    alu_opsc_o,
  output logic [3:0]    alu_func_o,
  output logic          alu_src_imm_o,
  output logic          reg_we_o,
  output logic          wb_sel_mem_o,
  output logic          halted_o,
  output logic          bus_err_o,
  output logic          illegal_op_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_LW    = 4'h3;
  localparam logic [3:0] OP_SW    = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       opc_q, opc_d;
  logic [2:0]       opsc_q, opsc_d;
  logic [3:0]       func_q, func_d;
  logic             bus_err_q, bus_err_d;

  logic [3:0] instr_op;
  logic       unused_instr_mid;
  assign instr_op         = instr_i[IW-1:IW-4];
  assign unused_instr_mid = ^instr_i[IW-5:4];

  assign alu_opsc_o = opsc_q;
  assign alu_func_o = func_q;
  assign bus_err_o  = bus_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      opc_q     <= '0;
      opsc_q    <= '0;
      func_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opc_q     <= opc_d;
      opsc_q    <= opsc_d;
      func_q    <= func_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    opc_d         = opc_q;
    opsc_d        = opsc_q;
    func_d        = func_q;
    bus_err_d     = bus_err_q;
    imem_req_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    ir_we_o       = 1'b0;
    pc_we_o       = 1'b0;
    pc_src_o      = 2'd0;
    alu_src_imm_o = 1'b0;
    reg_we_o      = 1'b0;
    wb_sel_mem_o  = 1'b0;
    halted_o      = 1'b0;
    illegal_op_o  = 1'b0;
    // Outputs stay quiet while reset is held even though state sits in FETCH
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ack_i) begin
            ir_we_o = 1'b1;
            pc_we_o = 1'b1;
            state_d = S_DECODE;
            // Capture the opcode while instr is guaranteed valid
            opc_d   = instr_op;
            func_d  = 4'd0;
            case (instr_op)
              OP_RTYPE: begin opsc_d = 3'b100; func_d = instr_i[3:0]; end
              OP_ANDI:  opsc_d = 3'b010;
              OP_BEQ:   opsc_d = 3'b001;
              default:  opsc_d = 3'b000;
            endcase
          end else if (cnt_q == CNT_LAST) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
          case (opc_q)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_LW, OP_SW,
            OP_BEQ, OP_JMP, OP_HALT: state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
            default: state_d = S_TRAP;
`else
            default: state_d = S_FETCH;
`endif
          endcase
        end
        S_EXEC: begin
          case (opc_q)
            OP_RTYPE: state_d = S_WB;
            OP_ADDI, OP_ANDI: begin
              alu_src_imm_o = 1'b1;
              state_d       = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_imm_o = 1'b1;
              state_d       = S_MEM;
            end
            OP_BEQ: begin
              pc_we_o  = zero_i;
              pc_src_o = zero_i ? 2'd1 : 2'd0;
              state_d  = S_FETCH;
            end
            OP_JMP: begin
              pc_we_o  = 1'b1;
              pc_src_o = 2'd2;
              state_d  = S_FETCH;
            end
            OP_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = (opc_q == OP_SW);
          if (dmem_ack_i) begin
            state_d = (opc_q == OP_SW) ? S_FETCH : S_WB;
          end else if (cnt_q == CNT_LAST) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          reg_we_o     = 1'b1;
          wb_sel_mem_o = (opc_q == OP_LW);
          state_d      = S_FETCH;
        end
        S_HALT: halted_o = 1'b1;
        S_TRAP: begin
          halted_o = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          illegal_op_o = 1'b1;
`endif
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm : directed bench for multicycle_ctrl_fsm
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        zero, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic [2:0]  alu_opsc;
  logic [3:0]  alu_func;
  logic        alu_src_imm, reg_we, wb_sel_mem, halted, bus_err, illegal_op;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.IW(16), .WAIT_MAX(15), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_i      (instr),
    .zero_i       (zero),
    .imem_req_o   (imem_req),
    .imem_ack_i   (imem_ack),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_ack_i   (dmem_ack),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .pc_src_o     (pc_src),
    .alu_opsc_o   (alu_opsc),
    .alu_func_o   (alu_func),
    .alu_src_imm_o(alu_src_imm),
    .reg_we_o     (reg_we),
    .wb_sel_mem_o (wb_sel_mem),
    .halted_o     (halted),
    .bus_err_o    (bus_err),
    .illegal_op_o (illegal_op)
  );

  // {imem_req,dmem_req,dmem_we,ir_we,pc_we}_{pc_src}_{imm,reg_we,wb_mem}_{halted,bus_err,illegal}
  logic [12:0] ctl;
  logic [6:0]  alu;
  assign ctl = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
                alu_src_imm, reg_we, wb_sel_mem, halted, bus_err, illegal_op};
  assign alu = {alu_opsc, alu_func};

  localparam logic [12:0] C_IDLE    = 13'b00000_00_000_000;
  localparam logic [12:0] C_FWAIT   = 13'b10000_00_000_000;
  localparam logic [12:0] C_FACK    = 13'b10011_00_000_000;
  localparam logic [12:0] C_IMM     = 13'b00000_00_100_000;
  localparam logic [12:0] C_WB      = 13'b00000_00_010_000;
  localparam logic [12:0] C_WB_LW   = 13'b00000_00_011_000;
  localparam logic [12:0] C_MEM_LW  = 13'b01000_00_000_000;
  localparam logic [12:0] C_MEM_SW  = 13'b01100_00_000_000;
  localparam logic [12:0] C_BEQ_T   = 13'b00001_01_000_000;
  localparam logic [12:0] C_JMP     = 13'b00001_10_000_000;
  localparam logic [12:0] C_HALT    = 13'b00000_00_000_100;
  localparam logic [12:0] C_HALT_BE = 13'b00000_00_000_110;
  localparam logic [12:0] C_TRAP    = 13'b00000_00_000_101;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts 1ns after an edge in FETCH; ack lands in the nwait-th request cycle
  task automatic do_fetch(input logic [15:0] ins, input int nwait);
    instr = ins;
    for (int i = 1; i < nwait; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("fetch_wait", 16'(ctl), 16'(C_FWAIT));
      tick();
    end
    imem_ack = 1'b1;
    @(negedge clk);
    chk("fetch_ack", 16'(ctl), 16'(C_FACK));
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic do_mem(input int nwait, input logic [12:0] exp);
    for (int i = 1; i < nwait; i++) begin
      dmem_ack = 1'b0;
      @(negedge clk);
      chk("mem_wait", 16'(ctl), 16'(exp));
      tick();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("mem_ack", 16'(ctl), 16'(exp));
    tick();
    dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_ctl", 16'(ctl), 16'(C_IDLE));
    chk("reset_alu", 16'(alu), 16'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("fetch_start", 16'(ctl), 16'(C_FWAIT));
    tick();
    rst_n = 1'b0;
    #1;
    chk("reset_mid_fetch", 16'(ctl), 16'(C_IDLE));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("fetch_restart", 16'(ctl), 16'(C_FWAIT));
    tick();

    // R-type func 7, ack in second request cycle
    do_fetch(16'h0127, 1);
    @(negedge clk); chk("r_dec_alu", 16'(alu), 16'h47); chk("r_dec_ctl", 16'(ctl), 16'(C_IDLE));
    tick(); @(negedge clk); chk("r_exec", 16'(ctl), 16'(C_IDLE));
    tick(); @(negedge clk); chk("r_wb", 16'(ctl), 16'(C_WB));
    tick();

    // LW with data ack in fourth cycle
    do_fetch(16'h3045, 1);
    @(negedge clk); chk("lw_dec_alu", 16'(alu), 16'h00);
    tick(); @(negedge clk); chk("lw_exec", 16'(ctl), 16'(C_IMM));
    tick();
    do_mem(4, C_MEM_LW);
    @(negedge clk); chk("lw_wb", 16'(ctl), 16'(C_WB_LW));
    tick();

    // SW returns straight to FETCH after MEM
    do_fetch(16'h4012, 1);
    @(negedge clk); chk("sw_dec_alu", 16'(alu), 16'h00);
    tick(); @(negedge clk); chk("sw_exec", 16'(ctl), 16'(C_IMM));
    tick();
    do_mem(1, C_MEM_SW);

    // BEQ taken, then not taken
    do_fetch(16'h5000, 1);
    @(negedge clk); chk("beq_dec_alu", 16'(alu), 16'h10);
    tick(); zero = 1'b1; @(negedge clk); chk("beq_taken", 16'(ctl), 16'(C_BEQ_T));
    tick(); zero = 1'b0;
    do_fetch(16'h5003, 1);
    tick(); @(negedge clk); chk("beq_not_taken", 16'(ctl), 16'(C_IDLE));
    chk("beq_exec_alu", 16'(alu), 16'h10);
    tick();

    // JMP
    do_fetch(16'h6000, 1);
    tick(); @(negedge clk); chk("jmp_exec", 16'(ctl), 16'(C_JMP));
    tick();

    // ANDI: function field forced to zero
    do_fetch(16'h2003, 1);
    @(negedge clk); chk("andi_dec_alu", 16'(alu), 16'h20);
    tick(); @(negedge clk); chk("andi_exec", 16'(ctl), 16'(C_IMM));
    tick(); @(negedge clk); chk("andi_wb", 16'(ctl), 16'(C_WB));
    tick();

    // ADDI with ack on the last permitted cycle: ack wins
    do_fetch(16'h1005, 15);
    @(negedge clk); chk("edge_ack_dec", 16'(ctl), 16'(C_IDLE)); chk("addi_dec_alu", 16'(alu), 16'h00);
    tick(); @(negedge clk); chk("addi_exec", 16'(ctl), 16'(C_IMM));
    tick(); @(negedge clk); chk("addi_wb", 16'(ctl), 16'(C_WB));
    tick();

    // Fetch timeout then late ack
    for (int i = 0; i < 15; i++) begin
      imem_ack = 1'b0;
      @(negedge clk); chk("timeout_wait", 16'(ctl), 16'(C_FWAIT));
      tick();
    end
    @(negedge clk); chk("timeout_halt", 16'(ctl), 16'(C_HALT_BE));
    tick(); imem_ack = 1'b1;
    @(negedge clk); chk("late_ack", 16'(ctl), 16'(C_HALT_BE));
    tick(); imem_ack = 1'b0;
    @(negedge clk); chk("halt_sticky", 16'(ctl), 16'(C_HALT_BE));
    tick();

    do_reset();
    @(negedge clk); chk("reset_clears_halt", 16'(ctl), 16'(C_FWAIT));
    tick();

    // HALT opcode
    do_fetch(16'hF000, 1);
    tick(); @(negedge clk); chk("halt_exec", 16'(ctl), 16'(C_IDLE));
    tick(); @(negedge clk); chk("halt_op", 16'(ctl), 16'(C_HALT));
    tick(); @(negedge clk); chk("halt_op_sticky", 16'(ctl), 16'(C_HALT));
    tick();

    do_reset();
    // Illegal opcode 0x9
    do_fetch(16'h9000, 1);
    @(negedge clk); chk("ill_dec", 16'(ctl), 16'(C_IDLE));
    tick();
`ifdef ILLEGAL_TRAP_EN
    @(negedge clk); chk("ill_trap", 16'(ctl), 16'(C_TRAP));
    tick(); @(negedge clk); chk("ill_trap_sticky", 16'(ctl), 16'(C_TRAP));
`else
    @(negedge clk); chk("ill_nop", 16'(ctl), 16'(C_FWAIT));
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle main control unit of the CPU.
- Fetches each instruction through an instruction-memory request/ack handshake and decodes the opcode.
- Sequences execute, memory and writeback phases.
- Drives the 3-bit opcode-class field (alu_opsc) and 4-bit function field (alu_func) consumed by the ALU control decoder, plus all datapath enables.

Parameters:
IW, 16, instruction width; opcode = instr[IW-1:IW-4], function = instr[3:0]
WAIT_MAX, 15, max cycles to wait for any memory ack before bus error
CNT_W, 4, width of the wait counter (must hold WAIT_MAX)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  IW  instruction word from instruction memory, valid with imem_ack
zero  in  1  ALU zero flag, sampled in EXEC
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction memory ack, 1-cycle pulse
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store) qualifier
dmem_ack  in  1  data memory ack, 1-cycle pulse
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target
alu_opsc  out  3  opcode class to ALU control
alu_func  out  4  function field to ALU control
alu_src_imm  out  1  ALU B operand = immediate
reg_we  out  1  register file write
wb_sel_mem  out  1  writeback source = memory data
halted  out  1  core halted (sticky)
bus_err  out  1  memory ack timeout (sticky)
illegal_op  out  1  illegal opcode trap (sticky, only with ILLEGAL_TRAP_EN)

Behaviour:
- Reset (async, rst_n=0): state=FETCH, wait counter=0, all outputs 0. Reset mid-handshake drops the request immediately.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- FETCH:
  - imem_req=1 held until imem_ack.
  - On ack, in the same cycle: ir_we=1, pc_we=1, pc_src=0; next state DECODE.
- DECODE: one cycle. Latches opcode and function into internal registers. Opcode map:
  - 0x0 R-type
  - 0x1 ADDI
  - 0x2 ANDI
  - 0x3 LW
  - 0x4 SW
  - 0x5 BEQ
  - 0x6 JMP
  - 0xF HALT
  - all other opcodes illegal
- alu_opsc/alu_func are registered and held stable from DECODE until the next FETCH:
  - R-type: opsc=3'b100, func=instr[3:0]
  - ADDI/LW/SW: opsc=3'b000 (add)
  - ANDI: opsc=3'b010
  - BEQ: opsc=3'b001 (compare)
  - func=0 for every opcode except R-type.
- EXEC:
  - alu_src_imm=1 for ADDI, ANDI, LW, SW.
  - R-type/ADDI/ANDI -> WB.
  - LW/SW -> MEM.
  - BEQ: if zero=1, pc_we=1 with pc_src=1; -> FETCH.
  - JMP: pc_we=1 with pc_src=2; -> FETCH.
  - HALT -> HALT.
- MEM:
  - dmem_req=1, plus dmem_we=1 for SW, held until dmem_ack.
  - SW -> FETCH; LW -> WB.
- WB: reg_we=1 for one cycle; wb_sel_mem=1 only for LW; -> FETCH.
- Latencies (FETCH cycles counted from request to ack inclusive):
  - R-type/ADDI/ANDI: FETCH + 3 cycles.
  - SW: FETCH + 2 + dmem wait.
  - LW: FETCH + 3 + dmem wait.
  - BEQ/JMP: FETCH + 2.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle without ack.
  - If it reaches WAIT_MAX without ack: drop the request, set bus_err=1, -> HALT.
  - An ack arriving in the same cycle the counter reaches WAIT_MAX wins (no error).
- Acks arriving outside FETCH/MEM are ignored.
- HALT: all enables 0, halted=1; exit only by reset.
- pc_we, ir_we, reg_we, dmem_req and imem_req are never asserted in HALT or TRAP.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to TRAP. TRAP sets illegal_op=1 and halted=1 (sticky, exit only by reset).
- Undefined: an illegal opcode is treated as a NOP (DECODE -> FETCH, no enables). illegal_op is tied to 0.

Test Plan:
- Reset asserted mid-fetch (imem_req=1) -> imem_req drops same cycle; after release FETCH restarts, all outputs 0.
- instr=0x0127 (R-type, func 7), ack after 2 cycles -> alu_opsc=100, alu_func=7; reg_we pulses 3 cycles after ack, wb_sel_mem=0.
- LW 0x3xxx with dmem_ack after 4 cycles -> alu_opsc=000, alu_src_imm=1, dmem_req held 4 cycles, dmem_we=0; then reg_we=1 with wb_sel_mem=1.
- BEQ 0x5xxx: zero=1 -> pc_we=1, pc_src=1 in EXEC; repeat with zero=0 -> no pc_we in EXEC, alu_opsc=001.
- No imem_ack for 15 cycles -> bus_err=1, halted=1, imem_req=0; a late ack changes nothing.
- Opcode 0x9 -> with ILLEGAL_TRAP_EN: illegal_op=1, halted=1; without it: next cycle FETCH, imem_req=1, illegal_op=0.
